// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined EX-stage shifter.
// Op codes, per-level fill selection and a width-generic bit reverse.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_SLL,
    SH_SRL,
    SH_SRA,
    SH_ROR
  } shift_op_e;

  typedef enum logic [1:0] {
    FILL_ZERO,
    FILL_SIGN,
    FILL_ROT
  } fill_e;

  localparam int unsigned MAXW = 64;

  // Only the low w bits are reversed; callers truncate to their width.
  function automatic logic [MAXW-1:0] bitrev(
    input logic [MAXW-1:0] d,
    input int unsigned     w
  );
    logic [MAXW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAXW; i++) begin
      if (i < w) r[i[5:0]] = d[6'(w - 1 - i)];
    end
    return r;
  endfunction

  function automatic fill_e fill_of(input shift_op_e op);
    fill_e f;
    f = FILL_ZERO;
    unique case (1'b1)
      op == SH_SRA: f = FILL_SIGN;
      op == SH_ROR: f = FILL_ROT;
      default:      f = FILL_ZERO;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/pipelined_shifter_level.sv
// One right-shift level of fixed distance DIST.
// Fill is zero, the carried sign bit, or the rotated-out low bits.
module shift_level
  import shifter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DIST = 1
) (
  input  logic [XLEN-1:0] data,
  input  logic            en,
  input  logic [1:0]      fill_mode,
  input  logic            sign,
  output logic [XLEN-1:0] res
);

  logic [DIST-1:0] fill;

  always_comb begin
    fill = '0;
    if (fill_mode == FILL_ROT) begin
      fill = data[DIST-1:0];
    end else if (fill_mode == FILL_SIGN) begin
      fill = {DIST{sign}};
    end
    res = en ? {fill, data[XLEN-1:DIST]} : data;
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined SLL/SRL/SRA/ROR shifter with valid/ready and flush.
// SLL runs the right-shift datapath on a bit-reversed operand.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_op,
  input  logic [XLEN-1:0]         in_data,
  input  logic [$clog2(XLEN)-1:0] in_amt,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int SHW = $clog2(XLEN);
  localparam int LPS = (SHW + PIPE_STAGES - 1) / PIPE_STAGES;
  localparam int LST = PIPE_STAGES - 1;

  typedef struct packed {
    logic            vld;
    shift_op_e       op;
    logic [XLEN-1:0] data;
    logic [SHW-1:0]  amt;
    logic [TAG_W-1:0] tag;
    logic            sign;
  } stage_t;

  stage_t    ent;
  stage_t    sin [PIPE_STAGES];
  stage_t    q   [PIPE_STAGES];
  shift_op_e op_in;
  logic      adv;

  assign op_in    = shift_op_e'(in_op);
  assign adv      = !q[LST].vld || out_ready;
  assign in_ready = adv;

  always_comb begin
    ent      = '0;
    ent.vld  = in_valid;
    ent.op   = op_in;
    ent.data = in_data;
    if (op_in == SH_SLL) begin
      ent.data = XLEN'(bitrev(64'(in_data), XLEN));
    end
    ent.amt  = in_amt;
    ent.tag  = in_tag;
    ent.sign = in_data[XLEN-1];
  end

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_st
    localparam int LO = s * LPS;
    localparam int HI = (LO + LPS > SHW) ? SHW : LO + LPS;

    logic [XLEN-1:0] ch [LPS+1];
    fill_e           fm;
    stage_t          so;

    if (s == 0) begin : g_first
      assign sin[s] = ent;
    end else begin : g_next
      assign sin[s] = q[s-1];
    end

    assign ch[0] = sin[s].data;
    assign fm    = fill_of(sin[s].op);

    // A stage may own fewer than LPS levels; the rest pass through.
    for (genvar j = 0; j < LPS; j++) begin : g_lvl
      if (LO + j < HI) begin : g_on
        shift_level #(
          .XLEN(XLEN),
          .DIST(1 << (LO + j))
        ) u_lvl (
          .data     (ch[j]),
          .en       (sin[s].amt[LO+j]),
          .fill_mode(fm),
          .sign     (sin[s].sign),
          .res      (ch[j+1])
        );
      end else begin : g_off
        assign ch[j+1] = ch[j];
      end
    end

    always_comb begin
      so      = sin[s];
      so.data = ch[LPS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q[s] <= '0;
      end else if (flush) begin
        q[s].vld <= 1'b0;
      end else if (adv) begin
        q[s] <= so;
      end
    end
  end

  assign out_valid = q[LST].vld;
  assign out_tag   = q[LST].tag;

  always_comb begin
    out_data = q[LST].data;
    if (q[LST].op == SH_SLL) begin
      out_data = XLEN'(bitrev(64'(q[LST].data), XLEN));
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter: directed ops, stall,
// flush, reset and a random sweep over widths and depths.
module tb_pipelined_shifter;
  import shifter_pkg::*;

  localparam int NC = 6;

  typedef struct {
    logic [63:0] d;
    logic [4:0]  t;
    int          c;
  } exp_t;

  int cw  [NC] = '{32, 32, 32, 32, 8, 64};
  int pst [NC] = '{2, 1, 3, 5, 2, 2};

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [1:0]  in_op;
  logic [63:0] in_data;
  logic [5:0]  in_amt;
  logic [4:0]  in_tag;

  logic        ir [NC];
  logic        ov [NC];
  logic [4:0]  ot [NC];
  logic [63:0] od [NC];
  logic [31:0] d0, d1, d2, d3;
  logic [7:0]  d4;
  logic [63:0] d5;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  exp_t q0 [$];
  exp_t sq [NC][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    od[0] = 64'(d0);
    od[1] = 64'(d1);
    od[2] = 64'(d2);
    od[3] = 64'(d3);
    od[4] = 64'(d4);
    od[5] = d5;
  end

  pipelined_shifter #(.XLEN(32), .PIPE_STAGES(2), .TAG_W(5)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .in_op(in_op),
    .in_data(in_data[31:0]), .in_amt(in_amt[4:0]), .in_tag(in_tag),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(d0), .out_tag(ot[0]));

  pipelined_shifter #(.XLEN(32), .PIPE_STAGES(1), .TAG_W(5)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .in_op(in_op),
    .in_data(in_data[31:0]), .in_amt(in_amt[4:0]), .in_tag(in_tag),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(d1), .out_tag(ot[1]));

  pipelined_shifter #(.XLEN(32), .PIPE_STAGES(3), .TAG_W(5)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[2]), .in_op(in_op),
    .in_data(in_data[31:0]), .in_amt(in_amt[4:0]), .in_tag(in_tag),
    .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(d2), .out_tag(ot[2]));

  pipelined_shifter #(.XLEN(32), .PIPE_STAGES(5), .TAG_W(5)) u3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[3]), .in_op(in_op),
    .in_data(in_data[31:0]), .in_amt(in_amt[4:0]), .in_tag(in_tag),
    .out_valid(ov[3]), .out_ready(out_ready),
    .out_data(d3), .out_tag(ot[3]));

  pipelined_shifter #(.XLEN(8), .PIPE_STAGES(2), .TAG_W(5)) u4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[4]), .in_op(in_op),
    .in_data(in_data[7:0]), .in_amt(in_amt[2:0]), .in_tag(in_tag),
    .out_valid(ov[4]), .out_ready(out_ready),
    .out_data(d4), .out_tag(ot[4]));

  pipelined_shifter #(.XLEN(64), .PIPE_STAGES(2), .TAG_W(5)) u5 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[5]), .in_op(in_op),
    .in_data(in_data), .in_amt(in_amt), .in_tag(in_tag),
    .out_valid(ov[5]), .out_ready(out_ready),
    .out_data(d5), .out_tag(ot[5]));

  function automatic logic [63:0] model(
    input logic [1:0]  op,
    input logic [63:0] din,
    input int          a,
    input int          w
  );
    logic [63:0] m, d, r;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    d = din & m;
    case (op)
      2'd0: r = d << a;
      2'd1: r = d >> a;
      2'd2: r = (d >> a) | (d[w-1] ? (m & ~(m >> a)) : 64'd0);
      default: r = (d >> a) | (d << (w - a));
    endcase
    return r & m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(
    input string       nm,
    input logic [1:0]  op,
    input logic [31:0] d,
    input int          a,
    input logic [4:0]  tg,
    input logic [31:0] ex
  );
    exp_t e;
    int   n;
    out_ready = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = 64'(d);
    in_amt    = 6'(a);
    in_tag    = tg;
    q0.push_back('{d: 64'(ex), t: tg, c: cyc});
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!ov[0] && n < 10) begin
      tick();
      n++;
    end
    tests++;
    if (!ov[0]) begin
      fails++;
      $display("FAIL %s_timeout: no out_valid in 10 cycles", nm);
      q0.delete();
      return;
    end
    e = q0.pop_front();
    tests++;
    if (od[0] !== e.d) begin
      fails++;
      $display("FAIL %s_data: got %h want %h", nm, od[0], e.d);
    end
    tests++;
    if (ot[0] !== e.t) begin
      fails++;
      $display("FAIL %s_tag: got %0d want %0d", nm, ot[0], e.t);
    end
    tests++;
    if (cyc - e.c != 2) begin
      fails++;
      $display("FAIL %s_lat: got %0d want 2", nm, cyc - e.c);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_op     = 2'd0;
    in_data   = '0;
    in_amt    = '0;
    in_tag    = '0;
    tick();
    tick();
    tests++;
    if (ov[0] !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid: got %b want 0", ov[0]);
    end
    tests++;
    if (ir[0] !== 1'b1) begin
      fails++;
      $display("FAIL rst_ready: got %b want 1", ir[0]);
    end
    tests++;
    if (od[0] !== 64'd0) begin
      fails++;
      $display("FAIL rst_data: got %h want 0", od[0]);
    end
    tests++;
    if (ot[0] !== 5'd0) begin
      fails++;
      $display("FAIL rst_tag: got %0d want 0", ot[0]);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ops();
    run_op("srl31", SH_SRL, 32'h8000_0000, 31, 5'd1, 32'h0000_0001);
    run_op("sra_neg", SH_SRA, 32'h8000_0000, 4, 5'd2, 32'hF800_0000);
    run_op("sra_pos", SH_SRA, 32'h7FFF_FFF0, 4, 5'd3, 32'h07FF_FFFF);
    run_op("sll31", SH_SLL, 32'h0000_0001, 31, 5'd4, 32'h8000_0000);
    run_op("ror1", SH_ROR, 32'h0000_0001, 1, 5'd5, 32'h8000_0000);
    run_op("ror8", SH_ROR, 32'h1234_5678, 8, 5'd6, 32'h7812_3456);
    run_op("sll4", SH_SLL, 32'hDEAD_BEEF, 4, 5'd7, 32'hEADB_EEF0);
    for (int op = 0; op < 4; op++) begin
      run_op("amt0", 2'(op), 32'hDEAD_BEEF, 0, 5'(8 + op), 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_back_to_back();
    int sent, got, stall, n;
    logic pv, pr;
    logic [63:0] pd;
    logic [4:0] pt;
    exp_t e;
    sent = 0; got = 0; stall = 0; n = 0;
    pv = 1'b0; pr = 1'b1; pd = '0; pt = '0;
    out_ready = 1'b0;
    while (got < 4 && n < 40) begin
      if (pv && !pr) begin
        tests++;
        if (ov[0] !== 1'b1 || od[0] !== pd || ot[0] !== pt) begin
          fails++;
          $display("FAIL bp_hold: got v=%b d=%h t=%0d want v=1 d=%h t=%0d",
                   ov[0], od[0], ot[0], pd, pt);
        end
      end
      if (ov[0] && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = (stall >= 3);
      end
      if (sent < 4) begin
        in_valid = 1'b1;
        in_op    = SH_ROR;
        in_data  = 64'(32'hA5 + sent);
        in_amt   = 6'(4 * (sent + 1));
        in_tag   = 5'(sent + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (ov[0] && !out_ready) begin
        tests++;
        if (ir[0] !== 1'b0) begin
          fails++;
          $display("FAIL bp_ready: got %b want 0", ir[0]);
        end
      end
      if (in_valid && ir[0]) begin
        q0.push_back('{d: model(in_op, in_data, int'(in_amt), 32),
                       t: in_tag, c: cyc});
        sent++;
      end
      if (ov[0] && out_ready) begin
        tests++;
        if (q0.size() == 0) begin
          fails++;
          $display("FAIL bp_dup: got t=%0d want no result", ot[0]);
        end else begin
          e = q0.pop_front();
          if (od[0] !== e.d || ot[0] !== e.t) begin
            fails++;
            $display("FAIL bp_order: got d=%h t=%0d want d=%h t=%0d",
                     od[0], ot[0], e.d, e.t);
          end
        end
        got++;
      end
      pv = ov[0];
      pr = out_ready;
      pd = od[0];
      pt = ot[0];
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (got != 4 || q0.size() != 0) begin
      fails++;
      $display("FAIL bp_count: got %0d results want 4", got);
    end
    q0.delete();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    int bad;
    out_ready = 1'b0;
    flush     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_op    = SH_SRL;
      in_data  = 64'h0F0;
      in_amt   = 6'(i);
      in_tag   = 5'(10 + i);
      tick();
    end
    in_tag = 5'd12;
    flush  = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (ov[0] !== 1'b0) begin
        fails++;
        $display("FAIL flush_valid%0d: got %b want 0", i, ov[0]);
      end
      tick();
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (ov[0] && ot[0] inside {5'd10, 5'd11, 5'd12}) bad++;
      tick();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL flush_leak: got %0d killed tags want 0", bad);
    end
    in_valid = 1'b1;
    in_tag   = 5'd13;
    flush    = 1'b1;
    #1;
    tests++;
    if (ir[0] !== 1'b1) begin
      fails++;
      $display("FAIL flush_idle_ready: got %b want 1", ir[0]);
    end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (ov[0]) bad++;
      tick();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL flush_same_cycle: got %0d results want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_op    = SH_SRL;
      in_data  = 64'hFFFF_FFFF;
      in_amt   = 6'(i + 1);
      in_tag   = 5'(20 + i);
      tick();
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || od[0] !== 64'd0) begin
      fails++;
      $display("FAIL rst_mid: got v=%b r=%b d=%h want v=0 r=1 d=0",
               ov[0], ir[0], od[0]);
    end
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    q0.delete();
    run_op("post_rst", SH_SRA, 32'hF000_0000, 8, 5'd9, 32'hFFF0_0000);
  endtask

  task automatic test_sweep();
    exp_t e;
    int a;
    out_ready = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    repeat (8) tick();
    for (int n = 0; n < 300; n++) begin
      for (int g = 0; g < NC; g++) begin
        if (ov[g]) begin
          tests++;
          if (sq[g].size() == 0) begin
            fails++;
            $display("FAIL sweep%0d_extra: got t=%0d want none", g, ot[g]);
          end else begin
            e = sq[g].pop_front();
            if (od[g] !== e.d || ot[g] !== e.t || cyc - e.c != pst[g]) begin
              fails++;
              $display("FAIL sweep%0d: got d=%h t=%0d lat=%0d want d=%h t=%0d lat=%0d",
                       g, od[g], ot[g], cyc - e.c, e.d, e.t, pst[g]);
            end
          end
        end
      end
      if (n < 280 && $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        in_op    = 2'($urandom_range(3));
        in_data  = {$urandom, $urandom};
        in_amt   = 6'($urandom_range(63));
        in_tag   = 5'($urandom_range(31));
        for (int g = 0; g < NC; g++) begin
          a = int'(in_amt) % cw[g];
          sq[g].push_back('{d: model(in_op, in_data, a, cw[g]),
                            t: in_tag, c: cyc});
        end
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    for (int g = 0; g < NC; g++) begin
      tests++;
      if (sq[g].size() != 0) begin
        fails++;
        $display("FAIL sweep%0d_lost: got %0d pending want 0", g, sq[g].size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
